// File: rtl/dog_diff_if.sv
// Beat-level handshake bundle for the DoG difference pipe: blur-layer inputs
// with valid/ready, and DoG samples with position flags and the clamp counter.
interface dog_diff_if #(
    parameter int PIX_W = 9,
    parameter int OUT_W = 10,
    parameter int LANES = 2
) ();
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*PIX_W-1:0] blur_a;
    logic [LANES*PIX_W-1:0] blur_b;
    logic [1:0]             mode;
    logic [OUT_W-2:0]       thresh;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*OUT_W-1:0] out_diff;
    logic [LANES-1:0]       out_above;
    logic                   out_eol;
    logic                   out_eof;
    logic [15:0]            sat_cnt;

    modport master (
        output in_valid, blur_a, blur_b, mode, thresh, out_ready,
        input  in_ready, out_valid, out_diff, out_above, out_eol, out_eof, sat_cnt
    );

    modport slave (
        input  in_valid, blur_a, blur_b, mode, thresh, out_ready,
        output in_ready, out_valid, out_diff, out_above, out_eol, out_eof, sat_cnt
    );
endinterface

// File: rtl/dog_diff_pipe.sv
// Two-stage multi-lane signed subtractor producing DoG samples from two blur
// layers, with wrap/abs/saturate output modes, threshold flags and frame position.
module dog_diff_pipe #(
    parameter int PIX_W = 9,
    parameter int OUT_W = 10,
    parameter int LANES = 2,
    parameter int COLS  = 640,
    parameter int ROWS  = 480
) (
    input logic     clk,
    input logic     rst,
    dog_diff_if.slave dif
);
    localparam int DW   = PIX_W + 1;
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int MAXV = 2**(OUT_W-1) - 1;
    localparam int MINV = -(2**(OUT_W-1));

    logic                   s1_valid_q;
    logic [LANES*DW-1:0]    s1_d_q, s1_d_d;
    logic [1:0]             s1_mode_q;
    logic [OUT_W-2:0]       s1_thresh_q;
    logic                   s2_valid_q;
    logic [LANES*OUT_W-1:0] diff_q, diff_d;
    logic [LANES-1:0]       above_q, above_d;
    logic [15:0]            sat_q, sat_d;
    logic [CW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;

    logic                   stall, out_fire, eol, eof;
    logic [15:0]            clamp_n;
    logic [16:0]            sat_sum;
    logic signed [31:0]     dw, mw, tw;

    assign stall    = s2_valid_q & ~dif.out_ready;
    assign out_fire = s2_valid_q & dif.out_ready;
    assign eol      = s2_valid_q & (col_q == CW'(COLS - LANES));
    assign eof      = eol & (row_q == RW'(ROWS - 1));

    assign dif.in_ready  = ~stall;
    assign dif.out_valid = s2_valid_q;
    assign dif.out_diff  = diff_q;
    assign dif.out_above = above_q;
    assign dif.out_eol   = eol;
    assign dif.out_eof   = eof;
    assign dif.sat_cnt   = sat_q;

    // Zero-extended operands make the PIX_W+1 bit difference exact.
    always_comb begin
        s1_d_d = '0;
        for (int l = 0; l < LANES; l++) begin
            s1_d_d[l*DW +: DW] = {1'b0, dif.blur_a[l*PIX_W +: PIX_W]}
                               - {1'b0, dif.blur_b[l*PIX_W +: PIX_W]};
        end
    end

    always_comb begin
        diff_d  = '0;
        above_d = '0;
        clamp_n = '0;
        dw      = '0;
        mw      = '0;
        tw      = signed'(32'(s1_thresh_q));
        for (int l = 0; l < LANES; l++) begin
            dw = 32'(signed'(s1_d_q[l*DW +: DW]));
            mw = (dw < 0) ? -dw : dw;
            above_d[l] = (mw > tw);
            case (s1_mode_q)
                2'b01: begin
                    if (mw > MAXV) begin
                        diff_d[l*OUT_W +: OUT_W] = OUT_W'(MAXV);
                        clamp_n = clamp_n + 16'd1;
                    end else begin
                        diff_d[l*OUT_W +: OUT_W] = OUT_W'(mw);
                    end
                end
                2'b10: begin
                    if (dw > MAXV) begin
                        diff_d[l*OUT_W +: OUT_W] = OUT_W'(MAXV);
                        clamp_n = clamp_n + 16'd1;
                    end else if (dw < MINV) begin
                        diff_d[l*OUT_W +: OUT_W] = OUT_W'(MINV);
                        clamp_n = clamp_n + 16'd1;
                    end else begin
                        diff_d[l*OUT_W +: OUT_W] = OUT_W'(dw);
                    end
                end
                default: diff_d[l*OUT_W +: OUT_W] = s1_d_q[l*DW +: OUT_W];
            endcase
        end
        sat_sum = {1'b0, sat_q} + {1'b0, clamp_n};
        sat_d   = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (out_fire) begin
            if (eol) begin
                col_d = '0;
                row_d = eof ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(LANES);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_d_q      <= '0;
            s1_mode_q   <= '0;
            s1_thresh_q <= '0;
            s2_valid_q  <= 1'b0;
            diff_q      <= '0;
            above_q     <= '0;
            sat_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
        end else begin
            if (!stall) begin
                s1_valid_q  <= dif.in_valid;
                s1_d_q      <= s1_d_d;
                s1_mode_q   <= dif.mode;
                s1_thresh_q <= dif.thresh;
                s2_valid_q  <= s1_valid_q;
                if (s1_valid_q) begin
                    diff_q  <= diff_d;
                    above_q <= above_d;
                    sat_q   <= sat_d;
                end
            end
            col_q <= col_d;
            row_q <= row_d;
        end
    end
endmodule

// File: tb/tb_dog_diff_pipe.sv
// Scoreboard bench: two pipes (OUT_W=10 and OUT_W=8) share stimulus; an
// arithmetic reference model predicts each beat, a negedge monitor checks.
module tb_dog_diff_pipe;
    localparam int COLS = 16;
    localparam int ROWS = 4;
    localparam int BPR  = COLS / 2;
    localparam int BPF  = BPR * ROWS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dog_diff_if #(.PIX_W(9), .OUT_W(10), .LANES(2)) if10 ();
    dog_diff_if #(.PIX_W(9), .OUT_W(8),  .LANES(2)) if8 ();

    dog_diff_pipe #(.PIX_W(9), .OUT_W(10), .LANES(2), .COLS(COLS), .ROWS(ROWS))
        u10 (.clk(clk), .rst(rst), .dif(if10));
    dog_diff_pipe #(.PIX_W(9), .OUT_W(8), .LANES(2), .COLS(COLS), .ROWS(ROWS))
        u8 (.clk(clk), .rst(rst), .dif(if8));

    typedef struct {
        logic [19:0] d10;
        logic [15:0] d8;
        logic [1:0]  ab10;
        logic [1:0]  ab8;
        logic        eol;
        logic        eof;
        int          sat10;
        int          sat8;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   pos   = 0;
    int   msat10 = 0;
    int   msat8  = 0;
    int   rmode = 0;
    int   rcnt  = 0;
    logic        prev_stall = 1'b0;
    logic [19:0] prev_diff  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void lane_model(input int a, input int b, input logic [1:0] m,
                                       input int th, input int ow,
                                       output int outv, output bit clamp, output bit above);
        int d, mag, mx, mn;
        d   = a - b;
        mag = (d < 0) ? -d : d;
        mx  = (1 << (ow - 1)) - 1;
        mn  = -(1 << (ow - 1));
        clamp = 1'b0;
        above = (mag > th);
        case (m)
            2'b01: begin clamp = (mag > mx); outv = clamp ? mx : mag; end
            2'b10: begin
                if (d > mx)      begin outv = mx; clamp = 1'b1; end
                else if (d < mn) begin outv = mn; clamp = 1'b1; end
                else             outv = d;
            end
            default: outv = d;
        endcase
        outv = outv & ((1 << ow) - 1);
    endfunction

    task automatic push_expected(input logic [17:0] a, input logic [17:0] b,
                                 input logic [1:0] m, input logic [8:0] th);
        exp_t e;
        int   ov, c10, c8, ai, bi;
        bit   cl, ab;
        e.d10 = '0; e.d8 = '0; e.ab10 = '0; e.ab8 = '0;
        c10 = 0; c8 = 0;
        for (int l = 0; l < 2; l++) begin
            ai = int'(a[l*9 +: 9]);
            bi = int'(b[l*9 +: 9]);
            lane_model(ai, bi, m, int'(th), 10, ov, cl, ab);
            e.d10[l*10 +: 10] = 10'(ov);
            e.ab10[l] = ab;
            c10 += int'(cl);
            lane_model(ai, bi, m, int'(th[6:0]), 8, ov, cl, ab);
            e.d8[l*8 +: 8] = 8'(ov);
            e.ab8[l] = ab;
            c8 += int'(cl);
        end
        msat10 = (msat10 + c10 > 65535) ? 65535 : msat10 + c10;
        msat8  = (msat8 + c8 > 65535)   ? 65535 : msat8 + c8;
        e.sat10 = msat10;
        e.sat8  = msat8;
        e.eol = ((pos + 1) % BPR) == 0;
        e.eof = (pos + 1) == BPF;
        pos   = (pos + 1) % BPF;
        q.push_back(e);
    endtask

    task automatic send(input logic [17:0] a, input logic [17:0] b,
                        input logic [1:0] m, input logic [8:0] th);
        int tries;
        tries = 0;
        if10.in_valid = 1'b1; if8.in_valid = 1'b1;
        if10.blur_a = a;  if8.blur_a = a;
        if10.blur_b = b;  if8.blur_b = b;
        if10.mode = m;    if8.mode = m;
        if10.thresh = th; if8.thresh = th[6:0];
        forever begin
            @(negedge clk);
            if (if10.in_ready) begin
                push_expected(a, b, m, th);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            tries++;
            if (tries > 200) begin
                total++; bad++;
                $display("FAIL send_timeout: in_ready stuck at %b, expected 1", if10.in_ready);
                break;
            end
        end
        if10.in_valid = 1'b0; if8.in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [1:0] m;
        m = 2'($urandom_range(0, 3));
        send(18'($urandom), 18'($urandom), m, 9'($urandom_range(0, 511)));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_left", 32'(q.size()), 32'd0);
    endtask

    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       if10.out_ready = 1'b1;
            1:       if10.out_ready = (rcnt % 3) == 0;
            default: if10.out_ready = 1'($urandom_range(0, 1));
        endcase
        if8.out_ready = if10.out_ready;
        rcnt++;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", 32'(if10.in_ready), 32'(!(if10.out_valid && !if10.out_ready)));
            chk("valid_pair", 32'(if8.out_valid), 32'(if10.out_valid));
            if (prev_stall) begin
                chk("stall_hold_diff", 32'(if10.out_diff), 32'(prev_diff));
                chk("stall_hold_valid", 32'(if10.out_valid), 32'd1);
            end
            if (if10.out_valid && if10.out_ready) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_beat: got %h expected none", if10.out_diff);
                end else begin
                    e = q.pop_front();
                    chk("diff10",  32'(if10.out_diff),  32'(e.d10));
                    chk("above10", 32'(if10.out_above), 32'(e.ab10));
                    chk("diff8",   32'(if8.out_diff),   32'(e.d8));
                    chk("above8",  32'(if8.out_above),  32'(e.ab8));
                    chk("eol",     32'(if10.out_eol),   32'(e.eol));
                    chk("eof",     32'(if10.out_eof),   32'(e.eof));
                    chk("sat10",   32'(if10.sat_cnt),   32'(e.sat10));
                    chk("sat8",    32'(if8.sat_cnt),    32'(e.sat8));
                end
            end else if (!if10.out_valid) begin
                chk("eol_idle", 32'({if10.out_eol, if10.out_eof}), 32'd0);
            end
            prev_stall = if10.out_valid && !if10.out_ready;
            prev_diff  = if10.out_diff;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        if10.in_valid = 1'b0; if8.in_valid = 1'b0;
        if10.blur_a = '0; if8.blur_a = '0;
        if10.blur_b = '0; if8.blur_b = '0;
        if10.mode = '0;   if8.mode = '0;
        if10.thresh = '0; if8.thresh = '0;
        if10.out_ready = 1'b1; if8.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_valid", 32'(if10.out_valid), 32'd0);
        chk("rst_diff",  32'(if10.out_diff),  32'd0);
        chk("rst_above", 32'(if10.out_above), 32'd0);
        chk("rst_sat",   32'(if10.sat_cnt),   32'd0);
        chk("rst_ready", 32'(if10.in_ready),  32'd1);
        @(posedge clk); #1;

        // lane0 a=5 b=6, lane1 a=6 b=5
        send({9'd6, 9'd5}, {9'd5, 9'd6}, 2'b00, 9'd0);
        chk("lat_stage1", 32'(if10.out_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_stage2", 32'(if10.out_valid), 32'd1);
        chk("lat_diff",   32'(if10.out_diff),  32'h0_07FF & 32'h0_07FF | 32'(20'h003FF));
        chk("lat_sat",    32'(if10.sat_cnt),   32'd0);

        send({9'd0, 9'd0},     {9'd0, 9'd511},   2'b00, 9'd100);
        send({9'd0, 9'd0},     {9'd0, 9'd511},   2'b01, 9'd100);
        send({9'd0, 9'd300},   {9'd0, 9'd300},   2'b01, 9'd100);
        send({9'd0, 9'd300},   {9'd300, 9'd0},   2'b10, 9'd100);
        send({9'd0, 9'd300},   {9'd300, 9'd0},   2'b00, 9'd100);
        send({9'd0, 9'd300},   {9'd300, 9'd0},   2'b11, 9'd100);
        drain();

        rmode = 1;
        for (int i = 0; i < 8; i++) send_rand();
        drain();

        rmode = 2;
        for (int i = 0; i < 150; i++) send_rand();
        drain();

        rmode = 0;
        for (int i = 0; i < 70; i++) send_rand();
        drain();

        for (int i = 0; i < 10; i++) send_rand();
        rst = 1'b1;
        q.delete();
        pos = 0; msat10 = 0; msat8 = 0;
        @(posedge clk); #1 rst = 1'b0;
        chk("mid_rst_valid", 32'(if10.out_valid), 32'd0);
        chk("mid_rst_sat10", 32'(if10.sat_cnt),   32'd0);
        chk("mid_rst_sat8",  32'(if8.sat_cnt),    32'd0);
        for (int i = 0; i < 20; i++) send_rand();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
